// File: rtl/neuron_pkg.sv
// Shared FSM state type and width helpers for the folded bitstream neuron.
// No logic of its own; widths are derived so accumulators can never overflow.
package neuron_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_OUT   = 1'b1
    } neuron_state_t;

    // Signed accumulator width: worst-case magnitude CYCLES*DIM_IN plus sign bit.
    function automatic int acc_width(input int cycles, input int dim_in);
        return $clog2(cycles * dim_in + 1) + 1;
    endfunction

    function automatic int pc_width(input int dim_in);
        return $clog2(dim_in + 1);
    endfunction

endpackage

// File: rtl/neuron_lane.sv
// One output-neuron lane: AND, popcount, signed add/sub into the selected accumulator, clip.
// Purely combinational (latency 0); no flow control of its own.
module neuron_lane
    import neuron_pkg::*;
#(
    parameter int DIM_IN = 16,
    parameter int INWD   = 8,
    parameter int ACCW   = 10,
    parameter int PCW    = 5
) (
    input  logic [DIM_IN-1:0]      input_rate,
    input  logic [DIM_IN-1:0]      weight,
    input  logic                   toggle,
    input  logic signed [ACCW-1:0] acc_cur,
    output logic signed [ACCW-1:0] acc_next,
    output logic [INWD-1:0]        clip_next
);

    localparam int MAXV = (1 << INWD) - 1;

    logic [DIM_IN-1:0]      hit;
    logic [PCW-1:0]         pc;
    logic signed [ACCW-1:0] pc_s;

    assign hit  = input_rate & weight;
    assign pc_s = ACCW'(pc);

    always_comb begin
        pc = '0;
        for (int i = 0; i < DIM_IN; i++) begin
            pc = pc + PCW'(hit[i]);
        end
    end

    assign acc_next = toggle ? (acc_cur - pc_s) : (acc_cur + pc_s);

    // ReLU floor at zero, saturate at the top of the INWD range.
    always_comb begin
        clip_next = '0;
        if (acc_next[ACCW-1]) begin
            clip_next = '0;
        end else if (int'(acc_next) > MAXV) begin
            clip_next = INWD'(MAXV);
        end else begin
            clip_next = INWD'(acc_next);
        end
    end

endmodule

// File: rtl/neuron_fold_seq.sv
// Folded bitstream neuron layer: G lanes time-shared over FOLD groups for CYCLES frames.
// Result valid 1 cycle after the last frame; input stalls (in_ready=0) until out_ready.
module neuron_fold_seq
    import neuron_pkg::*;
#(
    parameter int DIM_IN  = 16,
    parameter int DIM_OUT = 110,
    parameter int FOLD    = 1,
    parameter int INWD    = 8,
    parameter int CYCLES  = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   clear,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [DIM_IN-1:0]                      input_rate,
    input  logic [(DIM_OUT/FOLD)*DIM_IN-1:0]       weight_temporal,
    input  logic                                   toggle,
    output logic [((FOLD > 1) ? $clog2(FOLD) : 1)-1:0] fold_idx,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [DIM_OUT*INWD-1:0]                mac_out_clipped
);

    localparam int G    = DIM_OUT / FOLD;
    localparam int FW   = (FOLD > 1) ? $clog2(FOLD) : 1;
    localparam int CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam int ACCW = acc_width(CYCLES, DIM_IN);
    localparam int PCW  = pc_width(DIM_IN);

    neuron_state_t state_q, state_d;

    logic signed [ACCW-1:0] acc    [DIM_OUT];
    logic [INWD-1:0]        clip_q [DIM_OUT];
    logic signed [ACCW-1:0] acc_sel  [G];
    logic signed [ACCW-1:0] acc_next [G];
    logic [INWD-1:0]        clip_next [G];
    logic [FW-1:0]          fold_q;
    logic [CW-1:0]          cyc_cnt;

    logic in_fire, out_fire, last_frame;

    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign last_frame = (fold_q == FW'(FOLD - 1)) && (cyc_cnt == CW'(CYCLES - 1));
    assign fold_idx   = fold_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_fire && last_frame) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
        if (clear) begin
            state_d = ST_ACCUM;
        end
    end

    // Bank mux: each lane sees the accumulator of its neuron in the active group.
    always_comb begin
        for (int g = 0; g < G; g++) begin
            acc_sel[g] = acc[g];
            for (int f = 0; f < FOLD; f++) begin
                if (fold_q == FW'(f)) begin
                    acc_sel[g] = acc[f*G + g];
                end
            end
        end
    end

    for (genvar g = 0; g < G; g++) begin : g_lane
        neuron_lane #(
            .DIM_IN (DIM_IN),
            .INWD   (INWD),
            .ACCW   (ACCW),
            .PCW    (PCW)
        ) u_lane (
            .input_rate (input_rate),
            .weight     (weight_temporal[g*DIM_IN +: DIM_IN]),
            .toggle     (toggle),
            .acc_cur    (acc_sel[g]),
            .acc_next   (acc_next[g]),
            .clip_next  (clip_next[g])
        );
    end

    // Clipped outputs are registered alongside the accumulators so they stay
    // stable through the OUT state without any extra hold logic.
    always_ff @(posedge clk) begin
        if (!rst_n || clear || out_fire) begin
            for (int n = 0; n < DIM_OUT; n++) begin
                acc[n]    <= '0;
                clip_q[n] <= '0;
            end
            fold_q  <= '0;
            cyc_cnt <= '0;
        end else if (in_fire) begin
            for (int f = 0; f < FOLD; f++) begin
                for (int g = 0; g < G; g++) begin
                    if (fold_q == FW'(f)) begin
                        acc[f*G + g]    <= acc_next[g];
                        clip_q[f*G + g] <= clip_next[g];
                    end
                end
            end
            if (fold_q == FW'(FOLD - 1)) begin
                fold_q  <= '0;
                cyc_cnt <= (cyc_cnt == CW'(CYCLES - 1)) ? '0 : cyc_cnt + 1'b1;
            end else begin
                fold_q <= fold_q + 1'b1;
            end
        end
    end

    for (genvar n = 0; n < DIM_OUT; n++) begin : g_out
        assign mac_out_clipped[n*INWD +: INWD] = clip_q[n];
    end

endmodule

// File: tb/tb_neuron_fold_seq.sv
// Directed bench for neuron_fold_seq (DIM_IN=4, DIM_OUT=4, FOLD=2, CYCLES=4, INWD=3).
// Expected result vectors come from a bench-side accumulator model via a scoreboard queue.
`timescale 1ns/1ps
module tb_neuron_fold_seq;

    localparam int DIM_IN  = 4;
    localparam int DIM_OUT = 4;
    localparam int FOLD    = 2;
    localparam int INWD    = 3;
    localparam int CYCLES  = 4;
    localparam int G       = DIM_OUT / FOLD;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      clear = 1'b0;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic [DIM_IN-1:0]         input_rate = '0;
    logic [G*DIM_IN-1:0]       weight_temporal = '0;
    logic                      toggle = 1'b0;
    logic [0:0]                fold_idx;
    logic                      out_valid;
    logic                      out_ready = 1'b0;
    logic [DIM_OUT*INWD-1:0]   mac_out_clipped;

    neuron_fold_seq #(
        .DIM_IN (DIM_IN),
        .DIM_OUT(DIM_OUT),
        .FOLD   (FOLD),
        .INWD   (INWD),
        .CYCLES (CYCLES)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear           (clear),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .input_rate      (input_rate),
        .weight_temporal (weight_temporal),
        .toggle          (toggle),
        .fold_idx        (fold_idx),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .mac_out_clipped (mac_out_clipped)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int                      macc [DIM_OUT];
    int                      mfold = 0;
    int                      mcyc  = 0;
    logic [3:0]              wset [FOLD][G];
    logic [DIM_OUT*INWD-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int clip_model(input int v);
        if (v < 0) return 0;
        if (v > (1 << INWD) - 1) return (1 << INWD) - 1;
        return v;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < DIM_OUT; n++) macc[n] = 0;
        mfold = 0;
        mcyc  = 0;
    endtask

    task automatic set_weights(input logic [3:0] w00, input logic [3:0] w01,
                               input logic [3:0] w10, input logic [3:0] w11);
        wset[0][0] = w00; wset[0][1] = w01;
        wset[1][0] = w10; wset[1][1] = w11;
    endtask

    // One frame offered on a single cycle; the model follows only if accepted.
    task automatic send_frame(input logic [3:0] rate, input logic tog, input logic clr);
        logic [DIM_OUT*INWD-1:0] vec;
        int pc;
        @(negedge clk);
        chk("fold_idx_before_frame", 32'(fold_idx), 32'(mfold));
        chk("in_ready_before_frame", 32'(in_ready), 32'd1);
        in_valid        = 1'b1;
        input_rate      = rate;
        toggle          = tog;
        clear           = clr;
        weight_temporal = {wset[mfold][1], wset[mfold][0]};
        if (clr) begin
            model_reset();
        end else begin
            for (int g = 0; g < G; g++) begin
                pc = $countones(rate & wset[mfold][g]);
                macc[mfold*G + g] += tog ? -pc : pc;
            end
            if (mfold == FOLD - 1) begin
                mfold = 0;
                if (mcyc == CYCLES - 1) begin
                    for (int n = 0; n < DIM_OUT; n++)
                        vec[n*INWD +: INWD] = INWD'(clip_model(macc[n]));
                    exp_q.push_back(vec);
                    model_reset();
                end else begin
                    mcyc++;
                end
            end else begin
                mfold++;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic get_result(input string tag, output int waited,
                              output logic [DIM_OUT*INWD-1:0] expv);
        waited = 0;
        expv   = '0;
        while (out_valid !== 1'b1 && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_scoreboard_nonempty"}, 32'd0, 32'd1);
        end else begin
            expv = exp_q.pop_front();
            chk({tag, "_result"}, 32'(mac_out_clipped), 32'(expv));
        end
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_in_ready_after_ack"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid_after_ack"}, 32'(out_valid), 32'd0);
        chk({tag, "_outputs_zero_after_ack"}, 32'(mac_out_clipped), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited;
        logic [DIM_OUT*INWD-1:0] expv;
        logic [DIM_OUT*INWD-1:0] snap;

        model_reset();

        // Reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_fold_idx", 32'(fold_idx), 32'd0);
        chk("rst_outputs", 32'(mac_out_clipped), 32'd0);

        // Saturation: every neuron reaches 16, clipped to 7, latency 1
        set_weights(4'b1111, 4'b1111, 4'b1111, 4'b1111);
        for (int i = 0; i < FOLD*CYCLES; i++) send_frame(4'b1111, 1'b0, 1'b0);
        get_result("sat", waited, expv);
        chk("sat_latency", 32'(waited), 32'd0);
        chk("sat_const", 32'(mac_out_clipped), 32'hFFF);
        consume("sat");

        // Signed accumulation with idle gaps between frames
        set_weights(4'b0001, 4'b0011, 4'b0000, 4'b0111);
        for (int i = 0; i < FOLD*CYCLES; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send_frame(4'b0011, (i < FOLD) ? 1'b1 : 1'b0, 1'b0);
        end
        get_result("signed", waited, expv);
        chk("signed_const", 32'(mac_out_clipped), 32'({3'd4, 3'd0, 3'd4, 3'd2}));
        consume("signed");

        // ReLU floor
        set_weights(4'b1010, 4'b0110, 4'b1111, 4'b0001);
        for (int i = 0; i < FOLD*CYCLES; i++) send_frame(4'b1011, 1'b1, 1'b0);
        get_result("relu", waited, expv);
        chk("relu_const", 32'(mac_out_clipped), 32'd0);
        consume("relu");

        // Backpressure: frames offered during OUT must be ignored
        set_weights(4'b0001, 4'b0011, 4'b0111, 4'b0110);
        for (int i = 0; i < FOLD*CYCLES; i++) send_frame(4'b0011, 1'b0, 1'b0);
        get_result("bp", waited, snap);
        in_valid        = 1'b1;
        input_rate      = 4'b1111;
        weight_temporal = '1;
        toggle          = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_out_valid_hold", 32'(out_valid), 32'd1);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            chk("bp_outputs_stable", 32'(mac_out_clipped), 32'(snap));
            chk("bp_fold_idx_hold", 32'(fold_idx), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_after_ack", 32'(in_ready), 32'd1);
        chk("bp_fold_idx_after_ack", 32'(fold_idx), 32'd0);
        // Small per-frame popcount: leftovers from the stalled run would show up here
        set_weights(4'b1111, 4'b1111, 4'b1111, 4'b1111);
        for (int i = 0; i < FOLD*CYCLES; i++) send_frame(4'b0001, 1'b0, 1'b0);
        get_result("bp_fresh", waited, expv);
        chk("bp_fresh_const", 32'(mac_out_clipped), 32'({3'd4, 3'd4, 3'd4, 3'd4}));
        consume("bp_fresh");

        // Clear together with the 3rd frame
        set_weights(4'b1111, 4'b1111, 4'b1111, 4'b1111);
        send_frame(4'b1111, 1'b0, 1'b0);
        send_frame(4'b1111, 1'b0, 1'b0);
        send_frame(4'b1111, 1'b0, 1'b1);
        @(negedge clk);
        chk("clr_fold_idx", 32'(fold_idx), 32'd0);
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        chk("clr_outputs_zero", 32'(mac_out_clipped), 32'd0);
        for (int i = 0; i < FOLD*CYCLES - 1; i++) begin
            send_frame(4'b1111, 1'b0, 1'b0);
            chk("clr_no_early_result", 32'(out_valid), 32'd0);
        end
        send_frame(4'b1111, 1'b0, 1'b0);
        get_result("clr_fresh", waited, expv);
        chk("clr_fresh_latency", 32'(waited), 32'd0);
        chk("clr_fresh_const", 32'(mac_out_clipped), 32'hFFF);
        consume("clr_fresh");

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
